// File: rtl/reg_status_file.sv
// Architectural register file with a Tomasulo register-status (rename) table.
// Reads return the committed value or the ROB tag of the in-flight producer.
module reg_status_file #(
    parameter int ROB_ENTRY_WIDTH = 3,
    parameter int XLEN            = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4:0]                 rs1_addr,
    input  logic [4:0]                 rs2_addr,
    output logic [XLEN-1:0]            rs1_data,
    output logic [XLEN-1:0]            rs2_data,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    output logic [ROB_ENTRY_WIDTH-1:0] rs1_tag,
    output logic [ROB_ENTRY_WIDTH-1:0] rs2_tag,
    input  logic                       rename_en,
    input  logic [4:0]                 rename_rd,
    input  logic [ROB_ENTRY_WIDTH-1:0] rename_tag,
    input  logic                       commit_we,
    input  logic [4:0]                 commit_addr,
    input  logic [XLEN-1:0]            commit_data,
    input  logic [ROB_ENTRY_WIDTH-1:0] commit_tag,
    input  logic                       flush,
    output logic [31:0]                retired_count
);

    logic [XLEN-1:0]            regs [32];
    logic [ROB_ENTRY_WIDTH-1:0] tags [32];
    logic [31:0]                busy;
    logic [31:0]                retired_q;

    logic [1:0][4:0]                 rd_addr;
    logic [1:0][XLEN-1:0]            rd_data;
    logic [1:0]                      rd_busy;
    logic [1:0][ROB_ENTRY_WIDTH-1:0] rd_tag;

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    // Both read ports see the retiring commit; a same-cycle rename is not visible.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_tag  = '0;
        for (int p = 0; p < 2; p++) begin
            if (!rst && rd_addr[p] != 5'd0) begin
                rd_data[p] = (commit_we && commit_addr == rd_addr[p]) ? commit_data
                                                                       : regs[rd_addr[p]];
                rd_busy[p] = busy[rd_addr[p]] && !(commit_we && tags[rd_addr[p]] == commit_tag);
                rd_tag[p]  = rd_busy[p] ? tags[rd_addr[p]] : '0;
            end
        end
    end

    assign rs1_data      = rd_data[0];
    assign rs2_data      = rd_data[1];
    assign rs1_busy      = rd_busy[0];
    assign rs2_busy      = rd_busy[1];
    assign rs1_tag       = rd_tag[0];
    assign rs2_tag       = rd_tag[1];
    assign retired_count = retired_q;

    // Priority for the mapping: flush, then rename, then the matching commit clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
                tags[i] <= '0;
            end
            busy      <= '0;
            retired_q <= '0;
        end else begin
            if (commit_we) begin
                retired_q <= retired_q + 32'd1;
            end
            for (int i = 1; i < 32; i++) begin
                if (commit_we && commit_addr == 5'(i)) begin
                    regs[i] <= commit_data;
                end
                if (flush) begin
                    busy[i] <= 1'b0;
                    tags[i] <= '0;
                end else if (rename_en && rename_rd == 5'(i) && rename_tag != '0) begin
                    busy[i] <= 1'b1;
                    tags[i] <= rename_tag;
                end else if (commit_we && commit_addr == 5'(i) && busy[i] && tags[i] == commit_tag) begin
                    busy[i] <= 1'b0;
                    tags[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Bench for reg_status_file: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural register-status model.
module tb_reg_status_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic [2:0]  rs1_tag, rs2_tag;
    logic        rename_en;
    logic [4:0]  rename_rd;
    logic [2:0]  rename_tag;
    logic        commit_we;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;
    logic [2:0]  commit_tag;
    logic        flush;
    logic [31:0] retired_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic [2:0]  m_tag  [32];
    logic [31:0] m_count;
    logic        model_valid = 1'b0;

    reg_status_file #(.ROB_ENTRY_WIDTH(3), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag),
        .commit_we(commit_we), .commit_addr(commit_addr),
        .commit_data(commit_data), .commit_tag(commit_tag),
        .flush(flush), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                                 input logic ren, input logic [4:0] rrd, input logic [2:0] rtag,
                                 input logic cwe, input logic [4:0] caddr,
                                 input logic [31:0] cdata, input logic [2:0] ctag,
                                 input logic fl);
        @(posedge clk);
        #1;
        rst = r; rs1_addr = a1; rs2_addr = a2;
        rename_en = ren; rename_rd = rrd; rename_tag = rtag;
        commit_we = cwe; commit_addr = caddr; commit_data = cdata; commit_tag = ctag;
        flush = fl;
    endtask

    task automatic idleRead(input logic [4:0] a1, input logic [4:0] a2);
        applyStimulus(1'b0, a1, a2, 1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0);
    endtask

    // Reference model: commit retires the value, rename then claims the register,
    // flush then wipes every mapping; reset wipes everything.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
                m_tag[i]  = 3'd0;
            end
            m_count     = 32'h0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (commit_we) begin
                m_count = m_count + 32'd1;
                if (commit_addr != 5'd0) begin
                    m_regs[commit_addr] = commit_data;
                    if (m_busy[commit_addr] && m_tag[commit_addr] == commit_tag) begin
                        m_busy[commit_addr] = 1'b0;
                        m_tag[commit_addr]  = 3'd0;
                    end
                end
            end
            if (rename_en && rename_rd != 5'd0 && rename_tag != 3'd0) begin
                m_busy[rename_rd] = 1'b1;
                m_tag[rename_rd]  = rename_tag;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) begin
                    m_busy[i] = 1'b0;
                    m_tag[i]  = 3'd0;
                end
            end
        end
    end

    function automatic void modelRead(input logic [4:0] a, output logic [31:0] d,
                                      output logic b, output logic [2:0] t);
        d = 32'h0; b = 1'b0; t = 3'd0;
        if (!rst && a != 5'd0) begin
            d = (commit_we && commit_addr == a) ? commit_data : m_regs[a];
            b = m_busy[a] && !(commit_we && m_tag[a] == commit_tag);
            t = b ? m_tag[a] : 3'd0;
        end
    endfunction

    // Mid-cycle comparison of every output against the model.
    initial begin
        logic [31:0] ed;
        logic        eb;
        logic [2:0]  et;
        forever begin
            @(negedge clk);
            if (model_valid) begin
                modelRead(rs1_addr, ed, eb, et);
                checkOutput("rs1_data", rs1_data, ed);
                checkOutput("rs1_busy", {31'b0, rs1_busy}, {31'b0, eb});
                checkOutput("rs1_tag", {29'b0, rs1_tag}, {29'b0, et});
                modelRead(rs2_addr, ed, eb, et);
                checkOutput("rs2_data", rs2_data, ed);
                checkOutput("rs2_busy", {31'b0, rs2_busy}, {31'b0, eb});
                checkOutput("rs2_tag", {29'b0, rs2_tag}, {29'b0, et});
                checkOutput("retired_count", retired_count, m_count);
            end
        end
    end

    initial begin
        logic [4:0] ca;
        rst = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd0;
        rename_en = 1'b0; rename_rd = 5'd0; rename_tag = 3'd0;
        commit_we = 1'b0; commit_addr = 5'd0; commit_data = 32'h0; commit_tag = 3'd0;
        flush = 1'b0;
        applyStimulus(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0);

        idleRead(5'd5, 5'd0);
        @(negedge clk);
        checkOutput("lit_reset_data", rs1_data, 32'h0);
        checkOutput("lit_reset_busy", {31'b0, rs1_busy}, 32'd0);
        checkOutput("lit_reset_tag", {29'b0, rs1_tag}, 32'd0);
        checkOutput("lit_reset_count", retired_count, 32'd0);

        applyStimulus(1'b0, 5'd3, 5'd0, 1'b1, 5'd3, 3'd2, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0);
        idleRead(5'd3, 5'd0);
        @(negedge clk);
        checkOutput("lit_x3_busy", {31'b0, rs1_busy}, 32'd1);
        checkOutput("lit_x3_tag", {29'b0, rs1_tag}, 32'd2);
        applyStimulus(1'b0, 5'd3, 5'd0, 1'b0, 5'd0, 3'd0, 1'b1, 5'd3, 32'hDEADBEEF, 3'd2, 1'b0);
        @(negedge clk);
        checkOutput("lit_x3_bypass_data", rs1_data, 32'hDEADBEEF);
        checkOutput("lit_x3_bypass_busy", {31'b0, rs1_busy}, 32'd0);
        idleRead(5'd3, 5'd0);
        @(negedge clk);
        checkOutput("lit_x3_data", rs1_data, 32'hDEADBEEF);
        checkOutput("lit_x3_count", retired_count, 32'd1);

        applyStimulus(1'b0, 5'd4, 5'd0, 1'b1, 5'd4, 3'd1, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0);
        applyStimulus(1'b0, 5'd4, 5'd0, 1'b1, 5'd4, 3'd5, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0);
        applyStimulus(1'b0, 5'd4, 5'd0, 1'b0, 5'd0, 3'd0, 1'b1, 5'd4, 32'h11, 3'd1, 1'b0);
        idleRead(5'd4, 5'd0);
        @(negedge clk);
        checkOutput("lit_x4_old_data", rs1_data, 32'h11);
        checkOutput("lit_x4_young_busy", {31'b0, rs1_busy}, 32'd1);
        checkOutput("lit_x4_young_tag", {29'b0, rs1_tag}, 32'd5);
        applyStimulus(1'b0, 5'd4, 5'd0, 1'b0, 5'd0, 3'd0, 1'b1, 5'd4, 32'h22, 3'd5, 1'b0);
        idleRead(5'd4, 5'd0);
        @(negedge clk);
        checkOutput("lit_x4_data", rs1_data, 32'h22);
        checkOutput("lit_x4_busy", {31'b0, rs1_busy}, 32'd0);

        applyStimulus(1'b0, 5'd6, 5'd0, 1'b1, 5'd6, 3'd3, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0);
        @(negedge clk);
        checkOutput("lit_x6_same_cycle_busy", {31'b0, rs1_busy}, 32'd0);
        idleRead(5'd6, 5'd0);
        @(negedge clk);
        checkOutput("lit_x6_tag", {29'b0, rs1_tag}, 32'd3);

        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 3'd4, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 3'd6, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd10, 3'd7, 1'b1, 5'd9, 32'h55, 3'd2, 1'b1);
        idleRead(5'd7, 5'd8);
        @(negedge clk);
        checkOutput("lit_flush_x7_busy", {31'b0, rs1_busy}, 32'd0);
        checkOutput("lit_flush_x8_busy", {31'b0, rs2_busy}, 32'd0);
        checkOutput("lit_flush_count", retired_count, 32'd4);
        idleRead(5'd10, 5'd9);
        @(negedge clk);
        checkOutput("lit_flush_x10_busy", {31'b0, rs1_busy}, 32'd0);
        checkOutput("lit_flush_x9_data", rs2_data, 32'h55);

        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 3'd3, 1'b1, 5'd0, 32'hFFFF, 3'd3, 1'b0);
        @(negedge clk);
        checkOutput("lit_x0_bypass_data", rs1_data, 32'h0);
        idleRead(5'd0, 5'd3);
        @(negedge clk);
        checkOutput("lit_x0_busy", {31'b0, rs1_busy}, 32'd0);
        checkOutput("lit_x0_count", retired_count, 32'd5);

        applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 5'd11, 3'd1, 1'b1, 5'd12, 32'h77, 3'd0, 1'b0);
        @(negedge clk);
        checkOutput("lit_rst_held_data", rs1_data, 32'h0);
        idleRead(5'd11, 5'd3);
        @(negedge clk);
        checkOutput("lit_rst_x11_busy", {31'b0, rs1_busy}, 32'd0);
        checkOutput("lit_rst_x3_data", rs2_data, 32'h0);
        checkOutput("lit_rst_count", retired_count, 32'd0);

        // Random traffic over a small register window so mappings collide often.
        for (int n = 0; n < 1500; n++) begin
            ca = 5'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 199) == 0),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom), 5'($urandom_range(0, 7)), 3'($urandom),
                          1'($urandom), ca, $urandom,
                          ($urandom_range(0, 1) == 1) ? m_tag[ca] : 3'($urandom),
                          ($urandom_range(0, 29) == 0));
        end
        idleRead(5'd0, 5'd0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
